// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and helpers for the serial-in, parallel-out receiver.
//   state_e   - receiver FSM states (PARITY used only when SIPO_PARITY_EN is defined)
//   cnt_width - bit counter width needed to count 0..width inclusive
package sipo_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StParity
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// sipo_out_stage: registered valid/ready output port for completed words.
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   word_done    - one-cycle pulse: word_data holds a freshly completed word
//   word_data    - completed word
//   out_ready    - consumer accepts the held word when out_valid is also high
//   clr_overrun  - clears the sticky overrun flag (a simultaneous drop wins)
//   data_out     - held word; changes only when a new word is loaded
//   out_valid    - data_out holds an unconsumed word
//   overrun      - sticky: a completed word was dropped because the consumer stalled
module sipo_out_stage #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             word_done,
   input  logic [WIDTH-1:0] word_data,
   input  logic             out_ready,
   input  logic             clr_overrun,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             load, drop;

   always_comb begin
      // A new word may load when the slot is empty or is being emptied this cycle.
      load      = word_done && (!valid_q || out_ready);
      drop      = word_done && valid_q && !out_ready;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (load) begin
         data_d  = word_data;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (drop) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: LSB-first serial-in, parallel-out receiver.
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   serial_in     - serial data bit, sampled only when shift_en=1
//   shift_en      - bit strobe
//   frame_start   - current strobed bit is bit 0 of a new word (aborts any partial word)
//   parallel_out  - last completed word
//   out_valid     - parallel_out holds an unconsumed word
//   out_ready     - consumer accepts the word when out_valid && out_ready
//   busy          - a frame is partially received
//   overrun       - sticky: a completed word was dropped
//   clr_overrun   - clears overrun
//   parity_err    - (SIPO_PARITY_EN only) even-parity error of the held word
// Optional feature macro: SIPO_PARITY_EN adds a trailing even-parity bit per word.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             frame_start,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
`ifdef SIPO_PARITY_EN
   output logic             parity_err,
`endif
   input  logic             clr_overrun
);

   localparam int unsigned CntW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
   localparam int unsigned OutW = WIDTH + 1;
`else
   localparam int unsigned OutW = WIDTH;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] shifted;
   logic             last_data;
   logic             word_done;
   logic [OutW-1:0]  word_data;
   logic [OutW-1:0]  out_word;

   // New bit enters at the MSB so the first-received bit ends up in bit 0.
   assign shifted   = WIDTH'({serial_in, shreg_q} >> 1);
   assign last_data = (cnt_q == CntW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (shift_en && frame_start) begin
               shreg_d = shifted;
               cnt_d   = CntW'(1);
               state_d = StShift;
            end
         end
         StShift: begin
            if (shift_en) begin
               shreg_d = shifted;
               if (frame_start) begin
                  cnt_d = CntW'(1);
               end else if (last_data) begin
`ifdef SIPO_PARITY_EN
                  cnt_d   = CntW'(WIDTH);
                  state_d = StParity;
`else
                  cnt_d   = '0;
                  state_d = StIdle;
`endif
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
`ifdef SIPO_PARITY_EN
         StParity: begin
            if (shift_en) begin
               if (frame_start) begin
                  shreg_d = shifted;
                  cnt_d   = CntW'(1);
                  state_d = StShift;
               end else begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end
            end
         end
`endif
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: busy and the completion pulse that feeds the output stage
   always_comb begin
      busy = (state_q != StIdle);
`ifdef SIPO_PARITY_EN
      word_done = (state_q == StParity) && shift_en && !frame_start;
      word_data = {(^shreg_q) ^ serial_in, shreg_q};
`else
      word_done = (state_q == StShift) && shift_en && !frame_start && last_data;
      word_data = shifted;
`endif
   end

   sipo_out_stage #(
      .WIDTH (OutW)
   ) u_out_stage (
      .clk         (clk),
      .reset       (reset),
      .word_done   (word_done),
      .word_data   (word_data),
      .out_ready   (out_ready),
      .clr_overrun (clr_overrun),
      .data_out    (out_word),
      .out_valid   (out_valid),
      .overrun     (overrun)
   );

   assign parallel_out = out_word[WIDTH-1:0];
`ifdef SIPO_PARITY_EN
   assign parity_err = out_word[WIDTH];
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed plus randomized bench for sipo_deserializer (WIDTH=4).
// Expected outputs come from a frame-level reference model that collects strobed
// bits in a queue and builds each word arithmetically once a frame is complete.
module tb_sipo_deserializer;

   localparam int unsigned WIDTH = 4;
`ifdef SIPO_PARITY_EN
   localparam int unsigned FL = WIDTH + 1;
`else
   localparam int unsigned FL = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             serial_in;
   logic             shift_en;
   logic             frame_start;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             overrun;
   logic             clr_overrun;
`ifdef SIPO_PARITY_EN
   logic             parity_err;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic             m_bits[$];
   logic             m_in_frame = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   logic             m_valid = 1'b0;
   logic             m_overrun = 1'b0;
   logic             m_perr = 1'b0;

   sipo_deserializer #(
      .WIDTH (WIDTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_in    (serial_in),
      .shift_en     (shift_en),
      .frame_start  (frame_start),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .overrun      (overrun),
`ifdef SIPO_PARITY_EN
      .parity_err   (parity_err),
`endif
      .clr_overrun  (clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, advance the model, then compare after the edge.
   task automatic cycle(input logic rst, input logic se, input logic fs, input logic si,
                        input logic rdy, input logic clr);
      logic             done;
      logic [WIDTH-1:0] w;
      logic             pe;
      reset       = rst;
      shift_en    = se;
      frame_start = fs;
      serial_in   = si;
      out_ready   = rdy;
      clr_overrun = clr;
      done = 1'b0;
      w    = '0;
      pe   = 1'b0;
      if (rst) begin
         m_bits.delete();
         m_in_frame = 1'b0;
         m_data     = '0;
         m_valid    = 1'b0;
         m_overrun  = 1'b0;
         m_perr     = 1'b0;
      end else begin
         if (se) begin
            if (fs) begin
               m_bits.delete();
               m_bits.push_back(si);
               m_in_frame = 1'b1;
            end else if (m_in_frame) begin
               m_bits.push_back(si);
            end
            if (m_in_frame && m_bits.size() == FL) begin
               done = 1'b1;
               for (int i = 0; i < int'(WIDTH); i++) if (m_bits[i]) w[i] = 1'b1;
               for (int i = 0; i < int'(FL); i++) pe = pe ^ m_bits[i];
               m_bits.delete();
               m_in_frame = 1'b0;
            end
         end
         if (done && m_valid && !rdy) m_overrun = 1'b1;
         else if (clr) m_overrun = 1'b0;
         if (done && (!m_valid || rdy)) begin
            m_data  = w;
            m_perr  = pe;
            m_valid = 1'b1;
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("model_parallel_out", parallel_out, m_data);
      check("model_out_valid", out_valid, m_valid);
      check("model_busy", busy, m_in_frame);
      check("model_overrun", overrun, m_overrun);
`ifdef SIPO_PARITY_EN
      check("model_parity_err", parity_err, m_perr);
`endif
   endtask

   // Send one frame LSB first; gap idle cycles between strobes, rdy_last on the last strobe.
   task automatic send_word(input logic [WIDTH-1:0] val, input int gap, input logic rdy,
                            input logic rdy_last, input logic par);
      logic b;
      for (int i = 0; i < int'(FL); i++) begin
         b = (i < int'(WIDTH)) ? val[i] : par;
         cycle(1'b0, 1'b1, (i == 0), b, (i == int'(FL) - 1) ? rdy_last : rdy, 1'b0);
         if (i != int'(FL) - 1) begin
            for (int g = 0; g < gap; g++) begin
               cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy, 1'b0);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; serial_in = 1'b0; shift_en = 1'b0; frame_start = 1'b0;
      out_ready = 1'b0; clr_overrun = 1'b0;

      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("reset_parallel_out", parallel_out, 32'h0);
      check("reset_out_valid", out_valid, 32'h0);
      check("reset_busy", busy, 32'h0);
      check("reset_overrun", overrun, 32'h0);

      // Strobes without frame_start in IDLE are ignored
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check("idle_no_start_busy", busy, 32'h0);

      // Basic word 1,1,0,1 -> 4'hB
      send_word(4'hB, 0, 1'b1, 1'b1, 1'b1);
      check("basic_data", parallel_out, 32'hB);
      check("basic_valid", out_valid, 32'h1);
      check("basic_busy", busy, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("basic_valid_one_cycle", out_valid, 32'h0);

      // Gapped strobes
      send_word(4'hB, 3, 1'b1, 1'b1, 1'b1);
      check("gapped_data", parallel_out, 32'hB);
      check("gapped_valid", out_valid, 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Back-to-back with stalled consumer
      send_word(4'h5, 0, 1'b0, 1'b0, 1'b0);
      send_word(4'hA, 0, 1'b0, 1'b0, 1'b0);
      check("stall_data_kept", parallel_out, 32'h5);
      check("stall_overrun", overrun, 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("stall_drained", out_valid, 32'h0);
      check("stall_data_after", parallel_out, 32'h5);
      check("stall_overrun_sticky", overrun, 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("clr_overrun", overrun, 32'h0);

      // Simultaneous accept and complete
      send_word(4'h3, 0, 1'b0, 1'b0, 1'b0);
      check("simul_first", parallel_out, 32'h3);
      send_word(4'hC, 0, 1'b0, 1'b1, 1'b0);
      check("simul_data", parallel_out, 32'hC);
      check("simul_valid", out_valid, 32'h1);
      check("simul_overrun", overrun, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Abort: two bits then a new frame 0,0,1,1
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_word(4'hC, 0, 1'b1, 1'b1, 1'b0);
      check("abort_data", parallel_out, 32'hC);
      check("abort_valid", out_valid, 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset mid-frame
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("midrst_busy_before", busy, 32'h1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("midrst_busy", busy, 32'h0);
      check("midrst_valid", out_valid, 32'h0);
      send_word(4'h1, 0, 1'b1, 1'b1, 1'b1);
      check("midrst_next_data", parallel_out, 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
      send_word(4'h7, 0, 1'b1, 1'b1, 1'b0);
      check("parity_data", parallel_out, 32'h7);
      check("parity_err_set", parity_err, 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver for the LSB-first serial stream our shift-register transmitters emit.
- Samples one bit per qualified strobe and assembles WIDTH-bit words.
- Presents each completed word on a registered valid/ready output port and flags words dropped because the consumer stalled.
- Sits at the receive end of the on-chip serial link, feeding a parallel consumer.

Parameters:
- WIDTH, 4, data bits per word (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data bit; LSB of each word arrives first.
- shift_en  input  1  bit strobe; serial_in is sampled only when shift_en=1.
- frame_start  input  1  marks the current strobed bit as bit 0 of a new word; ignored when shift_en=0.
- parallel_out  output  WIDTH  last completed word.
- out_valid  output  1  parallel_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid&&out_ready.
- busy  output  1  a frame is partially received.
- overrun  output  1  sticky: a completed word was dropped.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs):
  - parallel_out=0, out_valid=0, busy=0, overrun=0.
  - Shift register and bit counter cleared; FSM goes to IDLE.
  - Reset mid-frame discards the partial word; no flag is raised.
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- IDLE:
  - shift_en&&frame_start: sample serial_in, cnt=1, go to SHIFT.
  - shift_en without frame_start: ignored, stay in IDLE.
- SHIFT:
  - Each strobe: shreg <= {serial_in, shreg[WIDTH-1:1]}, cnt++.
  - No strobe: hold all state.
  - When the WIDTH-th bit is sampled, the word completes and the FSM returns to IDLE.
- Word assembly: after WIDTH strobes, the first-received bit sits in parallel bit 0.
- Completion latency: parallel_out and out_valid update on the clock edge that samples the last bit, so they are visible in the following cycle.
- frame_start during SHIFT (with shift_en):
  - Partial word is aborted.
  - The current bit is taken as bit 0 of a new frame, cnt=1.
  - No flag is raised.
- Output handshake:
  - Transfer occurs when out_valid&&out_ready.
  - out_valid falls after a transfer unless a new word completes in the same cycle.
  - Word completes while out_valid=0: load parallel_out, set out_valid=1.
  - Word completes while out_valid=1 and out_ready=1 in the same cycle: new word loads, out_valid stays 1, no overrun.
  - Word completes while out_valid=1 and out_ready=0: new word is dropped, parallel_out is unchanged, overrun is set.
- overrun clearing:
  - clr_overrun clears overrun.
  - Simultaneous set and clear: set wins.
- busy=1 exactly while the FSM is not in IDLE.
- cnt width is $clog2(WIDTH+1). cnt never exceeds WIDTH, and no wrap-around occurs.
- parallel_out changes only on a word load; it is stable while out_valid=1.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- When defined:
  - After WIDTH data bits, the FSM enters PARITY and samples one more strobed bit as the even-parity bit.
  - The word completes on the parity strobe.
  - Adds output parity_err (1 bit), registered alongside parallel_out. It equals 1 when XOR of data and parity bit is 1.
  - parity_err follows the same load/drop rules as parallel_out; reset value is 0.
  - frame_start in PARITY aborts the frame, same as in SHIFT.
- When undefined: there is no PARITY state, no parity_err port, and the word completes on the WIDTH-th bit.

Decomposition:
- Package sipo_pkg contains:
  - state enum typedef (IDLE, SHIFT, PARITY).
  - function returning the counter width for a given WIDTH.
- One natural sub-module: sipo_out_stage. It holds the output register, handles the valid/ready handshake and the overrun/drop logic, and is driven by a one-cycle word_done pulse plus the word data.

Test Plan:
- All scenarios use WIDTH=4.
- Basic word: after reset, strobe bits 1,1,0,1 (frame_start on the first), out_ready=1 -> next cycle parallel_out=4'hB, out_valid=1 for one cycle, busy low.
- Gapped strobes: same bits with 3 idle cycles between strobes -> result identical (4'hB); busy high throughout the frame.
- Back-to-back with stalled consumer: out_ready=0, send 4'h5 then 4'hA -> parallel_out stays 4'h5, overrun=1; after out_ready=1 a single transfer of 4'h5 occurs; clr_overrun clears overrun.
- Simultaneous accept and complete: out_valid=1 (4'h3), out_ready=1 in the same cycle that 4'hC completes -> parallel_out=4'hC, out_valid stays 1, overrun=0.
- Abort: two bits sent, then frame_start with bits 0,0,1,1 -> parallel_out=4'hC; the partial word is never presented.
- Reset mid-frame: reset after 2 bits -> busy=0, out_valid=0. Next full frame 1,0,0,0 -> 4'h1. With SIPO_PARITY_EN, data 4'h7 with parity bit 0 -> parity_err=1.
